// File: rtl/micro_dispatch.sv
// micro_dispatch: instruction-side front end for the microcode sequencer.
// Fetches opcode bytes, maps each one to a microprogram entry address and
// expected length, presents the entry on seq_ir until the sequencer reports
// completion, and watches each microprogram against a step budget
// (expected length + WD_SLACK).
//
// Optional feature: define DISPATCH_PERF_EN to build the 16-bit
// retired-instruction counter on instr_count; otherwise instr_count is 0.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | stopped at an instruction boundary, waiting for run
// S_FETCH  | imem_rd high at pc, waiting for imem_valid
// S_DECODE | classify ir: halt / illegal / dispatch (seq_ir = 0)
// S_EXEC   | seq_ir = entry, waiting for seq_done or step-budget overrun
// S_GAP    | one idle cycle so the sequencer step counter returns to 0
// S_HALT   | halt opcode or timeout; held until reset
module micro_dispatch #(
    parameter int PC_W     = 8,
    parameter int WD_SLACK = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    output logic [PC_W-1:0] imem_addr,
    output logic            imem_rd,
    input  logic [7:0]      imem_data,
    input  logic            imem_valid,
    output logic [5:0]      seq_ir,
    input  logic            seq_done,
    output logic [PC_W-1:0] pc,
    output logic            halted,
    output logic            err_illegal,
    output logic            err_timeout,
    output logic [15:0]     instr_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_GAP,
        S_HALT
    } state_t;

    localparam logic [7:0] SLACK = 8'(WD_SLACK);

    state_t          state_q, state_nxt;
    logic [7:0]      ir_q;
    logic [5:0]      entry_q;
    logic [2:0]      len_q;
    logic [7:0]      cyc_q;
    logic [PC_W-1:0] pc_q;
    logic            err_ill_q;
    logic            err_to_q;

    logic [5:0]      dec_entry;
    logic [2:0]      dec_len;
    logic            is_halt;
    logic            is_ill;
    logic [7:0]      cyc_inc;
    logic [7:0]      step_limit;
    logic            timeout_hit;

    assign is_halt     = (ir_q[7:5] == 3'b111);
    assign is_ill      = (ir_q[7:5] != 3'b000) && !is_halt;
    assign cyc_inc     = cyc_q + 8'd1;
    assign step_limit  = {5'd0, len_q} + SLACK;
    // The current EXEC cycle is the one that brings the count to the limit.
    assign timeout_hit = (cyc_inc >= step_limit);

    // Opcode map: index ir[4:0] -> microprogram entry and expected length.
    always_comb begin
        dec_entry = 6'd0;
        dec_len   = 3'd0;
        case (ir_q[4:0])
            5'd0:  begin dec_entry = 6'd1;  dec_len = 3'd3; end
            5'd1:  begin dec_entry = 6'd4;  dec_len = 3'd4; end
            5'd2:  begin dec_entry = 6'd8;  dec_len = 3'd4; end
            5'd3:  begin dec_entry = 6'd12; dec_len = 3'd2; end
            5'd4:  begin dec_entry = 6'd14; dec_len = 3'd2; end
            5'd5:  begin dec_entry = 6'd16; dec_len = 3'd2; end
            5'd6:  begin dec_entry = 6'd18; dec_len = 3'd3; end
            5'd7:  begin dec_entry = 6'd21; dec_len = 3'd3; end
            5'd8:  begin dec_entry = 6'd24; dec_len = 3'd3; end
            5'd9:  begin dec_entry = 6'd27; dec_len = 3'd3; end
            5'd10: begin dec_entry = 6'd30; dec_len = 3'd3; end
            5'd11: begin dec_entry = 6'd33; dec_len = 3'd3; end
            5'd28: begin dec_entry = 6'd52; dec_len = 3'd2; end
            5'd29: begin dec_entry = 6'd54; dec_len = 3'd1; end
            5'd30: begin dec_entry = 6'd55; dec_len = 3'd1; end
            5'd31: begin dec_entry = 6'd56; dec_len = 3'd1; end
            // 12..27 are single-step microprograms laid out at 36..51.
            default: begin
                dec_entry = {1'b0, ir_q[4:0]} + 6'd24;
                dec_len   = 3'd1;
            end
        endcase
    end

    // Next-state and per-state outputs.
    always_comb begin
        state_nxt = state_q;
        imem_rd   = 1'b0;
        seq_ir    = 6'd0;
        halted    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                imem_rd = 1'b1;
                if (imem_valid) state_nxt = S_DECODE;
            end
            S_DECODE: begin
                if (is_halt)     state_nxt = S_HALT;
                else if (is_ill) state_nxt = run ? S_FETCH : S_IDLE;
                else             state_nxt = S_EXEC;
            end
            S_EXEC: begin
                seq_ir = entry_q;
                // Completion takes priority over a same-cycle overrun.
                if (seq_done)         state_nxt = S_GAP;
                else if (timeout_hit) state_nxt = S_HALT;
            end
            S_GAP: begin
                state_nxt = run ? S_FETCH : S_IDLE;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register plus datapath registers updated per state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ir_q      <= 8'd0;
            entry_q   <= 6'd0;
            len_q     <= 3'd0;
            cyc_q     <= 8'd0;
            pc_q      <= '0;
            err_ill_q <= 1'b0;
            err_to_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            case (state_q)
                S_FETCH: begin
                    if (imem_valid) ir_q <= imem_data;
                end
                S_DECODE: begin
                    if (is_ill) begin
                        err_ill_q <= 1'b1;
                        pc_q      <= pc_q + 1'b1;
                    end else if (!is_halt) begin
                        entry_q <= dec_entry;
                        len_q   <= dec_len;
                        cyc_q   <= 8'd0;
                    end
                end
                S_EXEC: begin
                    cyc_q <= cyc_inc;
                    if (!seq_done && timeout_hit) err_to_q <= 1'b1;
                end
                S_GAP: begin
                    pc_q <= pc_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef DISPATCH_PERF_EN
    logic [15:0] count_q;

    // Retired-instruction counter; wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                             count_q <= 16'd0;
        else if (state_q == S_EXEC && seq_done) count_q <= count_q + 16'd1;
    end

    assign instr_count = count_q;
`else
    assign instr_count = 16'd0;
`endif

    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign err_illegal = err_ill_q;
    assign err_timeout = err_to_q;

endmodule

// File: tb/tb_micro_dispatch.sv
// Self-checking bench for micro_dispatch: opcode-map vector table, hand-written
// corner sequences and randomized programs checked against a program-level
// reference model (walks the program, predicts dispatched entries and holds).
module tb_micro_dispatch;

    localparam int PC_W  = 8;
    localparam int SLACK = 4;
`ifdef DISPATCH_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            run = 1'b0;
    logic [PC_W-1:0] imem_addr;
    logic            imem_rd;
    logic [7:0]      imem_data = 8'd0;
    logic            imem_valid = 1'b0;
    logic [5:0]      seq_ir;
    logic            seq_done = 1'b0;
    logic [PC_W-1:0] pc;
    logic            halted;
    logic            err_illegal;
    logic            err_timeout;
    logic [15:0]     instr_count;

    micro_dispatch #(.PC_W(PC_W), .WD_SLACK(SLACK)) dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .imem_addr(imem_addr), .imem_rd(imem_rd),
        .imem_data(imem_data), .imem_valid(imem_valid),
        .seq_ir(seq_ir), .seq_done(seq_done), .pc(pc),
        .halted(halted), .err_illegal(err_illegal),
        .err_timeout(err_timeout), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint outs_now();
        return longint'({imem_addr, imem_rd, seq_ir, pc, halted,
                         err_illegal, err_timeout, instr_count});
    endfunction

    function automatic longint exp_count(input int n);
        return PERF ? longint'(n % 65536) : 0;
    endfunction

    // Opcode map written straight from the published table.
    int ent_tab[32];
    int len_tab[32];

    logic [7:0] mem[256];
    int         delays[64];
    bit         patch_wrap;

    int tr_entry[$];
    int tr_hold[$];
    int fetch_addr[$];
    int lat_bad, gap_bad, stable_bad, idle_bad, idle_pc;

    int exp_entry[$];
    int exp_hold[$];
    int exp_pc, exp_n;
    bit exp_ill, exp_to;

    task automatic do_reset();
        rst_n      = 1'b0;
        run        = 1'b0;
        imem_valid = 1'b0;
        imem_data  = 8'd0;
        seq_done   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", outs_now(), 0);
        rst_n = 1'b1;
    endtask

    // Drives imem and a sequencer responder, records what the DUT dispatched.
    // drop_k: drop run when dispatch #drop_k appears; reset_k: pull rst_n then.
    task automatic run_prog(input int drop_k, input int reset_k, input int max_cycles);
        int t, prev_ir, cur_hold, ordinal, zero_run, fetch_wait, cur_lat;
        int t_acc, t_done, dropped;
        tr_entry.delete(); tr_hold.delete(); fetch_addr.delete();
        lat_bad = 0; gap_bad = 0; stable_bad = 0; idle_bad = 0; idle_pc = -1;
        prev_ir = 0; cur_hold = 0; ordinal = -1; zero_run = 100; fetch_wait = 0;
        cur_lat = $urandom_range(0, 2); t_acc = -100; t_done = -100; dropped = 0;
        run = 1'b1;
        t = 0;
        while (t < max_cycles) begin
            @(posedge clk);
            #1;
            t++;
            if (seq_ir != 6'd0) begin
                if (prev_ir == 0) begin
                    if (zero_run < 2) gap_bad++;
                    if (t != t_acc + 2) lat_bad++;
                    tr_entry.push_back(int'(seq_ir));
                    cur_hold = 0;
                    ordinal++;
                    if (ordinal == drop_k) begin
                        run = 1'b0;
                        dropped = 1;
                    end
                    if (ordinal == reset_k) begin
                        check("count_before_reset", longint'(instr_count), exp_count(reset_k));
                        #2 rst_n = 1'b0;
                        #1;
                        check("async_reset_outputs", outs_now(), 0);
                        seq_done = 1'b0;
                        imem_valid = 1'b0;
                        return;
                    end
                end else if (int'(seq_ir) != prev_ir) begin
                    stable_bad++;
                end
                cur_hold++;
                zero_run = 0;
            end else begin
                if (prev_ir != 0) tr_hold.push_back(cur_hold);
                zero_run++;
            end
            prev_ir = int'(seq_ir);

            if (t == t_done + 2 && imem_rd != run) lat_bad++;
            if (dropped == 2) begin
                if (t >= t_done + 2 && imem_rd) idle_bad++;
                if (t == t_done + 20) begin
                    idle_pc = int'(pc);
                    run = 1'b1;
                    dropped = 3;
                end
            end

            if (seq_ir != 6'd0 && cur_hold == delays[ordinal]) begin
                seq_done = 1'b1;
                t_done = t;
                if (dropped == 1) dropped = 2;
            end else begin
                seq_done = (seq_ir == 6'd0) && ($urandom_range(0, 3) == 0);
            end

            if (imem_rd) begin
                if (fetch_wait >= cur_lat) begin
                    imem_valid = 1'b1;
                    imem_data  = mem[imem_addr];
                    fetch_addr.push_back(int'(imem_addr));
                    if (patch_wrap && imem_addr == 8'hFF) mem[0] = 8'hE0;
                    t_acc = t;
                    fetch_wait = 0;
                    cur_lat = $urandom_range(0, 2);
                end else begin
                    imem_valid = 1'b0;
                    imem_data  = 8'($urandom);
                    fetch_wait++;
                end
            end else begin
                imem_valid = ($urandom_range(0, 2) == 0);
                imem_data  = 8'($urandom);
                fetch_wait = 0;
            end

            if (halted) break;
        end
        seq_done   = 1'b0;
        imem_valid = 1'b0;
    endtask

    // Program-level reference: walk memory, predict dispatches and final state.
    task automatic run_model();
        int p, k, idx, l, guard;
        logic [7:0] op;
        exp_entry.delete(); exp_hold.delete();
        p = 0; k = 0; exp_n = 0; exp_ill = 0; exp_to = 0;
        for (guard = 0; guard < 1000; guard++) begin
            op = mem[p];
            if (op[7:5] == 3'b111) break;
            if (op[7:5] != 3'b000) begin
                exp_ill = 1;
                p = (p + 1) % 256;
                continue;
            end
            idx = int'(op[4:0]);
            l = len_tab[idx];
            if (delays[k] > l + SLACK) begin
                exp_entry.push_back(ent_tab[idx]);
                exp_hold.push_back(l + SLACK);
                exp_to = 1;
                break;
            end
            exp_entry.push_back(ent_tab[idx]);
            exp_hold.push_back(delays[k]);
            exp_n++;
            k++;
            p = (p + 1) % 256;
        end
        exp_pc = p;
    endtask

    task automatic compare_run(input string tag);
        check({tag, "_ndisp"}, tr_entry.size(), exp_entry.size());
        for (int i = 0; i < tr_entry.size() && i < exp_entry.size(); i++) begin
            check({tag, "_entry"}, tr_entry[i], exp_entry[i]);
            if (i < tr_hold.size()) check({tag, "_hold"}, tr_hold[i], exp_hold[i]);
        end
        check({tag, "_pc"}, longint'(pc), exp_pc);
        check({tag, "_halted"}, longint'(halted), 1);
        check({tag, "_err_illegal"}, longint'(err_illegal), longint'(exp_ill));
        check({tag, "_err_timeout"}, longint'(err_timeout), longint'(exp_to));
        check({tag, "_instr_count"}, longint'(instr_count), exp_count(exp_n));
        check({tag, "_latency"}, lat_bad, 0);
        check({tag, "_gap"}, gap_bad, 0);
        check({tag, "_stable"}, stable_bad, 0);
    endtask

    task automatic fill_mem(input logic [7:0] v);
        for (int i = 0; i < 256; i++) mem[i] = v;
    endtask

    task automatic fill_delays(input int d);
        for (int i = 0; i < 64; i++) delays[i] = d;
    endtask

    typedef struct {
        logic [7:0] op;
        int         entry;
        int         hold;
        bit         ill;
        bit         to;
        int         pc;
    } vec_t;

    initial begin
        int e0[12];
        int l0[12];
        int e1[4];
        int l1[4];
        vec_t vecs[$];
        vec_t v;
        int n, r;

        e0 = '{1, 4, 8, 12, 14, 16, 18, 21, 24, 27, 30, 33};
        l0 = '{3, 4, 4, 2, 2, 2, 3, 3, 3, 3, 3, 3};
        e1 = '{52, 54, 55, 56};
        l1 = '{2, 1, 1, 1};
        for (int i = 0; i < 12; i++) begin ent_tab[i] = e0[i]; len_tab[i] = l0[i]; end
        for (int i = 12; i < 28; i++) begin ent_tab[i] = 36 + (i - 12); len_tab[i] = 1; end
        for (int i = 0; i < 4; i++) begin ent_tab[28 + i] = e1[i]; len_tab[28 + i] = l1[i]; end
        patch_wrap = 1'b0;

        // Vector table: each opcode alone with a silent sequencer.
        for (int i = 0; i < 32; i++) begin
            v.op = 8'(i); v.entry = ent_tab[i]; v.hold = len_tab[i] + SLACK;
            v.ill = 0; v.to = 1; v.pc = 0;
            vecs.push_back(v);
        end
        v = '{8'h40, 0, 0, 1'b1, 1'b0, 1}; vecs.push_back(v);
        v = '{8'hBF, 0, 0, 1'b1, 1'b0, 1}; vecs.push_back(v);
        v = '{8'hE0, 0, 0, 1'b0, 1'b0, 0}; vecs.push_back(v);
        v = '{8'hFF, 0, 0, 1'b0, 1'b0, 0}; vecs.push_back(v);

        foreach (vecs[i]) begin
            fill_mem(8'hE0);
            mem[0] = vecs[i].op;
            fill_delays(1000);
            do_reset();
            run_prog(-1, -1, 200);
            check("vec_ndisp", tr_entry.size(), vecs[i].entry != 0 ? 1 : 0);
            if (tr_entry.size() > 0 && tr_hold.size() > 0) begin
                check("vec_entry", tr_entry[0], vecs[i].entry);
                check("vec_exec_cycles", tr_hold[0], vecs[i].hold);
            end
            check("vec_err_illegal", longint'(err_illegal), longint'(vecs[i].ill));
            check("vec_err_timeout", longint'(err_timeout), longint'(vecs[i].to));
            check("vec_pc", longint'(pc), vecs[i].pc);
            check("vec_halted", longint'(halted), 1);
            check("vec_seq_ir_halt", longint'(seq_ir), 0);
        end

        // [0x00, 0xE0] with a 3-cycle sequencer.
        fill_mem(8'hE0); mem[0] = 8'h00; fill_delays(3);
        do_reset();
        run_prog(-1, -1, 200);
        run_model();
        compare_run("seq_single");
        check("seq_single_hold3", tr_hold.size() > 0 ? tr_hold[0] : -1, 3);
        check("seq_single_pc1", longint'(pc), 1);

        // [0x0C, 0x1D, 0x01] then halt.
        fill_mem(8'hE0); mem[0] = 8'h0C; mem[1] = 8'h1D; mem[2] = 8'h01;
        delays[0] = 1; delays[1] = 2; delays[2] = 4;
        do_reset();
        run_prog(-1, -1, 300);
        run_model();
        compare_run("seq_three");
        check("seq_three_2nd", tr_entry.size() > 1 ? tr_entry[1] : -1, 54);
        check("seq_three_pc3", longint'(pc), 3);

        // Illegal opcode at pc=5: next fetch must be at 6.
        fill_mem(8'hE0);
        for (int i = 0; i < 5; i++) mem[i] = 8'h0D;
        mem[5] = 8'h40;
        fill_delays(2);
        do_reset();
        run_prog(-1, -1, 400);
        run_model();
        compare_run("seq_illegal");
        check("seq_illegal_nfetch", fetch_addr.size(), 7);
        check("seq_illegal_next_addr", fetch_addr.size() > 6 ? fetch_addr[6] : -1, 6);

        // run dropped during EXEC of opcode 0x02.
        fill_mem(8'hE0); mem[0] = 8'h02; fill_delays(3);
        do_reset();
        run_prog(0, -1, 400);
        run_model();
        compare_run("seq_drop");
        check("seq_drop_idle_rd", idle_bad, 0);
        check("seq_drop_idle_pc", idle_pc, 1);

        // Three retirements, then reset mid-EXEC of the fourth.
        fill_mem(8'hE0); mem[0] = 8'h0C; mem[1] = 8'h0D; mem[2] = 8'h0E; mem[3] = 8'h01;
        fill_delays(2);
        do_reset();
        run_prog(-1, 3, 400);

        // pc wrap: 256 illegal opcodes, halt appears at address 0 on the second pass.
        fill_mem(8'h20); fill_delays(1);
        patch_wrap = 1'b1;
        do_reset();
        run_prog(-1, -1, 3000);
        patch_wrap = 1'b0;
        check("wrap_nfetch", fetch_addr.size(), 257);
        check("wrap_last_addr", fetch_addr.size() > 256 ? fetch_addr[256] : -1, 0);
        check("wrap_pc", longint'(pc), 0);
        check("wrap_halted", longint'(halted), 1);
        check("wrap_err_illegal", longint'(err_illegal), 1);

        // Randomized programs against the reference model.
        for (int it = 0; it < 30; it++) begin
            fill_mem(8'hE0);
            n = $urandom_range(3, 20);
            for (int i = 0; i < n; i++) begin
                r = $urandom_range(0, 19);
                if (r < 16) mem[i] = 8'($urandom_range(0, 31));
                else        mem[i] = {3'($urandom_range(1, 6)), 5'($urandom)};
            end
            mem[n] = {3'b111, 5'($urandom)};
            for (int i = 0; i < 64; i++) delays[i] = $urandom_range(1, 7);
            do_reset();
            run_prog(-1, -1, 2000);
            run_model();
            compare_run("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
